avalon_data_master: RTL and testbench
=====================================

AVALON_DATA_MASTER -- requirements
Module: avalon_data_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the watchdog limit in clock cycles and is used only when AVM_DATA_TIMEOUT_EN is defined.
REQ-002 CLK  input  1  is the single clock; all logic SHALL be rising-edge.
REQ-003 RST_N  input  1  is the asynchronous, active-low reset.
REQ-004 RRam  input  1  is the core read request, held as a level until done_ext.
REQ-005 WRam  input  1  is the core write request, held as a level until done_ext.
REQ-006 daddr  input  32  is the core data byte address.
REQ-007 ddata_w  input  32  is the core write data.
REQ-008 ddata_r  output  32  is the registered read data returned to the core.
REQ-009 done_ext  output  1  is a one-cycle completion pulse to the core.
REQ-010 avm_address  output  32  is the word-aligned Avalon address, {daddr[31:2],2'b00}.
REQ-011 avm_read and avm_write  output  1 each  are the Avalon read and write commands.
REQ-012 avm_writedata  output  32  and avm_byteenable  output  4  SHALL drive registered ddata_w and the constant 4'hF.
REQ-013 avm_readdata  input  32, avm_readdatavalid  input  1, and avm_waitrequest  input  1  are the Avalon slave returns.
REQ-014 err  output  1  is a sticky timeout flag.

Function
REQ-015 The FSM SHALL have the states IDLE, RD_CMD, RD_WAIT, WR_CMD and DONE, and all Avalon outputs SHALL be registered.
REQ-016 A transaction SHALL start only on a rising edge of RRam or WRam, detected against a registered previous value, so that a level still held after DONE does not re-issue the transaction.
REQ-017 When both edges occur in the same cycle, the block SHALL serve the write first; the read SHALL be served afterwards only if RRam is still high, and it then counts as a pending edge.
REQ-018 IDLE to RD_CMD: avm_read=1 and avm_address and avm_writedata SHALL be latched from daddr and ddata_w one cycle after the edge.
REQ-019 RD_CMD SHALL hold avm_read and avm_address stable while avm_waitrequest=1.
REQ-020 When avm_waitrequest=0 in RD_CMD, the block SHALL drop avm_read and go to RD_WAIT; if avm_readdatavalid=1 in that same cycle, it SHALL capture the data and go straight to DONE.
REQ-021 RD_WAIT SHALL capture avm_readdata into ddata_r on avm_readdatavalid and go to DONE; avm_readdatavalid seen in any other state SHALL be ignored.
REQ-022 WR_CMD SHALL hold avm_write, avm_address and avm_writedata until avm_waitrequest=0, then go to DONE.
REQ-023 DONE SHALL assert done_ext for exactly one cycle and then return to IDLE.
REQ-024 Minimum latency from request edge to done_ext SHALL be 3 cycles with zero wait-states.
REQ-025 ddata_r SHALL hold its last captured value until the next read completes; writes SHALL NOT alter it.

Reset
REQ-026 Asserting RST_N=0 at any time, including mid-transaction, SHALL immediately force state IDLE, avm_read=0, avm_write=0, done_ext=0, err=0, and ddata_r, avm_address and avm_writedata to 0.
REQ-027 After reset release, a request already high SHALL count as a rising edge on the first sampled cycle.

Configuration
REQ-028 With AVM_DATA_TIMEOUT_EN defined, a counter SHALL run in RD_CMD, RD_WAIT and WR_CMD and clear on entry to IDLE.
REQ-029 With AVM_DATA_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL drop the command, load ddata_r=32'hDEADBEEF on a read, set err, and go to DONE.
REQ-030 Without AVM_DATA_TIMEOUT_EN, no counter SHALL exist, err SHALL be tied to 0, and the block SHALL wait indefinitely.

Structure
REQ-031 Package avm_data_pkg SHALL hold the state enum, BE_ALL=4'hF and TIMEOUT_DATA=32'hDEADBEEF.
REQ-032 The timeout counter SHALL be sub-module avm_watchdog (inputs: clk, reset, run; output: expired), instantiated only under AVM_DATA_TIMEOUT_EN.

Verification
REQ-033 Zero-wait read: the bench SHALL drive RRam edge with daddr=32'h0000_1006 and, on the cycle after avm_read, avm_readdatavalid with data 32'hCAFE_0001; the block SHALL respond with avm_address=32'h0000_1004, ddata_r=32'hCAFE_0001, and done_ext 3 cycles after the edge.
REQ-034 Write with waitrequest: the bench SHALL drive WRam edge with ddata_w=32'h1234_5678 and hold avm_waitrequest=1 for 4 cycles; the block SHALL hold avm_write and data for 5 cycles, then pulse done_ext once.
REQ-035 Simultaneous requests: the bench SHALL raise RRam and WRam together and keep both high; the block SHALL complete the write first, then the read, with two done_ext pulses and no third.
REQ-036 Held level: the bench SHALL keep RRam high for 10 cycles after done_ext; the block SHALL issue no new avm_read.
REQ-037 Reset mid-read: the bench SHALL assert RST_N=0 in RD_WAIT; all outputs SHALL be 0 in the same cycle, and a late avm_readdatavalid after release SHALL be ignored.
REQ-038 Timeout (macro defined, TIMEOUT_CYCLES=8): the bench SHALL hold avm_waitrequest=1 on a read; the block SHALL set err=1, load ddata_r=32'hDEADBEEF, and pulse done_ext after 8 cycles.

Source files
------------

// File: rtl/avm_data_pkg.sv
// Shared types and constants for the Avalon data master.
// Contents: FSM state enum, bus widths, byte-enable and timeout constants,
// and a word-alignment helper for byte addresses.
package avm_data_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [BE_W-1:0]   BE_ALL       = 4'hF;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;
  localparam logic [ADDR_W-1:0] WORD_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_WAIT = 3'd2,
    WR_CMD  = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Clear the byte-offset bits of a byte address.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/avm_watchdog.sv
// Cycle watchdog for outstanding Avalon commands.
// Ports: clk      - rising-edge clock
//        reset    - asynchronous, active-low reset
//        run      - high while a command is outstanding; low clears the count
//        expired  - high during the TIMEOUT_CYCLES-th consecutive cycle of run
module avm_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count busy cycles, saturating at the limit so expired stays asserted.
  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = run && (cnt_q == LIMIT);

endmodule

// File: rtl/avalon_data_master.sv
// Bridges a level-based core data request (RRam/WRam) onto an Avalon-MM
// master port; one transaction per request rising edge, write served first
// when both rise together.
// Ports: CLK, RST_N (async active-low); core side RRam, WRam, daddr, ddata_w,
//        ddata_r, done_ext; Avalon side avm_address, avm_read, avm_write,
//        avm_writedata, avm_byteenable, avm_readdata, avm_readdatavalid,
//        avm_waitrequest; err (sticky timeout flag).
// Build option: AVM_DATA_TIMEOUT_EN adds the TIMEOUT_CYCLES watchdog; when
// undefined, commands wait indefinitely and err is tied low.
module avalon_data_master
  import avm_data_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RRam,
  input  logic              WRam,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] ddata_w,
  output logic [DATA_W-1:0] ddata_r,
  output logic              done_ext,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [BE_W-1:0]   avm_byteenable,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic              err
);

  state_e            state_q, state_d;
  logic              rram_q, wram_q;
  logic              rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic              avm_read_q, avm_read_d, avm_write_q, avm_write_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              rd_req_c, wr_req_c, start_rd_c, start_wr_c, timeout_c;

  // A request is a fresh rising edge, or an edge deferred while busy.
  assign rd_req_c = RRam & (~rram_q | rd_pend_q);
  assign wr_req_c = WRam & (~wram_q | wr_pend_q);

`ifdef AVM_DATA_TIMEOUT_EN
  logic err_q, err_d;
  logic run_c;

  assign run_c = (state_q == RD_CMD) || (state_q == RD_WAIT) || (state_q == WR_CMD);

  avm_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (CLK),
    .reset  (RST_N),
    .run    (run_c),
    .expired(timeout_c)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign timeout_c = 1'b0;
  assign err       = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      rram_q      <= 1'b0;
      wram_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      avm_read_q  <= 1'b0;
      avm_write_q <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rram_q      <= RRam;
      wram_q      <= WRam;
      rd_pend_q   <= rd_pend_d;
      wr_pend_q   <= wr_pend_d;
      avm_read_q  <= avm_read_d;
      avm_write_q <= avm_write_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    avm_read_d  = avm_read_q;
    avm_write_d = avm_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    start_rd_c  = 1'b0;
    start_wr_c  = 1'b0;
`ifdef AVM_DATA_TIMEOUT_EN
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (wr_req_c) begin
          state_d     = WR_CMD;
          avm_write_d = 1'b1;
          addr_d      = word_align(daddr);
          wdata_d     = ddata_w;
          start_wr_c  = 1'b1;
        end else if (rd_req_c) begin
          state_d    = RD_CMD;
          avm_read_d = 1'b1;
          addr_d     = word_align(daddr);
          wdata_d    = ddata_w;
          start_rd_c = 1'b1;
        end
      end
      RD_CMD: begin
        // Command accepted; data may return in the same cycle.
        if (!avm_waitrequest) begin
          avm_read_d = 1'b0;
          if (avm_readdatavalid) begin
            rdata_d = avm_readdata;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      WR_CMD: begin
        if (!avm_waitrequest) begin
          avm_write_d = 1'b0;
          state_d     = DONE;
          done_d      = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef AVM_DATA_TIMEOUT_EN
    // Watchdog expiry overrides normal completion of a stuck command.
    if (timeout_c) begin
      avm_read_d  = 1'b0;
      avm_write_d = 1'b0;
      if (state_q != WR_CMD) rdata_d = TIMEOUT_DATA;
      err_d       = 1'b1;
      state_d     = DONE;
      done_d      = 1'b1;
    end
`endif

    // Remember edges that could not be served this cycle while the level holds.
    rd_pend_d = RRam & (rd_pend_q | ~rram_q) & ~start_rd_c;
    wr_pend_d = WRam & (wr_pend_q | ~wram_q) & ~start_wr_c;
  end

  assign ddata_r        = rdata_q;
  assign done_ext       = done_q;
  assign avm_address    = addr_q;
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = BE_ALL;

endmodule

// File: tb/tb_avalon_data_master.sv
// Self-checking bench for avalon_data_master: scenario tasks with a
// scoreboard of expected completion results (read data, err).
module tb_avalon_data_master;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        RRam = 1'b0;
  logic        WRam = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] ddata_w = '0;
  logic [31:0] ddata_r;
  logic        done_ext;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic        err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rdata = '0;
  logic        model_err = 1'b0;
  logic [31:0] slave_data = '0;
  int          n_rd_issue = 0;
  int          n_wr_issue = 0;

  avalon_data_master #(.TIMEOUT_CYCLES(8)) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .RRam             (RRam),
    .WRam             (WRam),
    .daddr            (daddr),
    .ddata_w          (ddata_w),
    .ddata_r          (ddata_r),
    .done_ext         (done_ext),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest  (avm_waitrequest),
    .err              (err)
  );

  always #5 CLK = ~CLK;

  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_t x;
    x.rdata = d;
    x.err   = e;
    sb.push_back(x);
  endtask

  function automatic bit pop_exp(output exp_t e);
    if (sb.size() == 0) return 1'b0;
    e = sb.pop_front();
    return 1'b1;
  endfunction

  // One clock of a simple slave: readdatavalid the cycle after avm_read drops.
  task automatic step_slave(output bit done_seen);
    logic pr, pw;
    pr = avm_read;
    pw = avm_write;
    @(posedge CLK); #1;
    if (avm_read === 1'b1 && pr !== 1'b1) n_rd_issue++;
    if (avm_write === 1'b1 && pw !== 1'b1) n_wr_issue++;
    avm_readdatavalid = (pr === 1'b1) && (avm_read === 1'b0);
    avm_readdata      = avm_readdatavalid ? slave_data : 32'h0;
    done_seen         = (done_ext === 1'b1);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({avm_read, avm_write, done_ext, err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: read/write/done/err=%b required 0000", {avm_read, avm_write, done_ext, err});
    end
    checks++;
    if (ddata_r !== 32'h0 || avm_address !== 32'h0 || avm_writedata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: ddata_r=%h addr=%h wdata=%h required 0", ddata_r, avm_address, avm_writedata);
    end
    checks++;
    if (avm_byteenable !== 4'hF) begin
      failures++;
      $display("FAIL byteenable: got %h required f", avm_byteenable);
    end
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (avm_read !== 1'b0 || avm_write !== 1'b0 || done_ext !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: read=%b write=%b done=%b required 0", avm_read, avm_write, done_ext);
    end
  endtask

  task automatic test_zero_wait_read();
    bit   d;
    int   lat;
    exp_t e;
    slave_data  = 32'hCAFE_0001;
    model_rdata = slave_data;
    push_exp(model_rdata, model_err);
    daddr   = 32'h0000_1006;
    ddata_w = 32'hAAAA_5555;
    RRam    = 1'b1;
    step_slave(d);
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'h0000_1004) begin
      failures++;
      $display("FAIL rd_cmd: read=%b addr=%h required 1 00001004", avm_read, avm_address);
    end
    checks++;
    if (avm_writedata !== 32'hAAAA_5555) begin
      failures++;
      $display("FAIL rd_wdata_latch: got %h required aaaa5555", avm_writedata);
    end
    lat = 1;
    while (!d && lat < 20) begin
      step_slave(d);
      lat++;
    end
    checks++;
    if (!d || lat != 3) begin
      failures++;
      $display("FAIL rd_latency: done=%0d after %0d cycles required 3", d, lat);
    end
    checks++;
    if (!pop_exp(e)) begin
      failures++;
      $display("FAIL rd_sb: done_ext with no expected entry");
    end else if (ddata_r !== e.rdata || err !== e.err) begin
      failures++;
      $display("FAIL rd_data: ddata_r=%h err=%b required %h %b", ddata_r, err, e.rdata, e.err);
    end
    RRam = 1'b0;
    step_slave(d);
    checks++;
    if (done_ext !== 1'b0) begin
      failures++;
      $display("FAIL rd_done_pulse: done_ext=%b required 0", done_ext);
    end
  endtask

  task automatic test_write_wait();
    bit   d;
    int   wr_cycles;
    exp_t e;
    push_exp(model_rdata, model_err);
    daddr           = 32'h2000_0003;
    ddata_w         = 32'h1234_5678;
    avm_waitrequest = 1'b1;
    WRam            = 1'b1;
    wr_cycles       = 0;
    for (int i = 0; i < 5; i++) begin
      step_slave(d);
      if (i == 0) ddata_w = 32'h0;
      if (avm_write === 1'b1 && avm_writedata === 32'h1234_5678 && avm_address === 32'h2000_0000)
        wr_cycles++;
      if (d) wr_cycles += 100;
      if (i == 4) avm_waitrequest = 1'b0;
    end
    checks++;
    if (wr_cycles != 5) begin
      failures++;
      $display("FAIL wr_hold: held-cycle score %0d required 5", wr_cycles);
    end
    step_slave(d);
    checks++;
    if (!d || avm_write !== 1'b0) begin
      failures++;
      $display("FAIL wr_done: done=%0d write=%b required 1 0", d, avm_write);
    end
    checks++;
    if (!pop_exp(e)) begin
      failures++;
      $display("FAIL wr_sb: done_ext with no expected entry");
    end else if (ddata_r !== e.rdata || err !== e.err) begin
      failures++;
      $display("FAIL wr_keeps_rdata: ddata_r=%h err=%b required %h %b", ddata_r, err, e.rdata, e.err);
    end
    WRam = 1'b0;
    step_slave(d);
    checks++;
    if (done_ext !== 1'b0) begin
      failures++;
      $display("FAIL wr_done_pulse: done_ext=%b required 0", done_ext);
    end
  endtask

  task automatic test_simultaneous();
    bit   d;
    bit   got_first, first_is_write;
    int   dones, r0, w0;
    exp_t e;
    push_exp(model_rdata, model_err);
    slave_data  = 32'hBEEF_0002;
    model_rdata = slave_data;
    push_exp(model_rdata, model_err);
    daddr     = 32'h0000_3008;
    ddata_w   = 32'h55AA_55AA;
    r0        = n_rd_issue;
    w0        = n_wr_issue;
    dones     = 0;
    got_first = 1'b0;
    first_is_write = 1'b0;
    RRam = 1'b1;
    WRam = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step_slave(d);
      if (!got_first && (avm_read === 1'b1 || avm_write === 1'b1)) begin
        got_first      = 1'b1;
        first_is_write = (avm_write === 1'b1);
      end
      if (d) begin
        dones++;
        checks++;
        if (!pop_exp(e)) begin
          failures++;
          $display("FAIL sim_sb: extra done_ext number %0d", dones);
        end else if (ddata_r !== e.rdata || err !== e.err) begin
          failures++;
          $display("FAIL sim_data: done %0d ddata_r=%h required %h", dones, ddata_r, e.rdata);
        end
      end
    end
    checks++;
    if (dones != 2 || !first_is_write) begin
      failures++;
      $display("FAIL sim_order: dones=%0d first_write=%0d required 2 1", dones, first_is_write);
    end
    checks++;
    if (n_rd_issue - r0 != 1 || n_wr_issue - w0 != 1) begin
      failures++;
      $display("FAIL sim_issues: reads=%0d writes=%0d required 1 1", n_rd_issue - r0, n_wr_issue - w0);
    end
    RRam = 1'b0;
    WRam = 1'b0;
    step_slave(d);
  endtask

  task automatic test_held_level();
    bit   d;
    int   n, dn, r0;
    exp_t e;
    slave_data  = 32'h1357_2468;
    model_rdata = slave_data;
    push_exp(model_rdata, model_err);
    daddr = 32'h0000_4000;
    RRam  = 1'b1;
    n = 0;
    d = 1'b0;
    while (!d && n < 20) begin
      step_slave(d);
      n++;
    end
    checks++;
    if (!d) begin
      failures++;
      $display("FAIL held_first_done: no done_ext within %0d cycles", n);
    end else if (!pop_exp(e) || ddata_r !== e.rdata) begin
      failures++;
      $display("FAIL held_data: ddata_r=%h required %h", ddata_r, model_rdata);
    end
    r0 = n_rd_issue;
    dn = 0;
    repeat (10) begin
      step_slave(d);
      if (d) dn++;
    end
    checks++;
    if (n_rd_issue != r0 || dn != 0) begin
      failures++;
      $display("FAIL held_reissue: new reads=%0d dones=%0d required 0 0", n_rd_issue - r0, dn);
    end
    RRam = 1'b0;
    step_slave(d);
  endtask

  task automatic test_reset_mid_read();
    daddr = 32'h0000_5000;
    RRam  = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (avm_read !== 1'b0 || avm_address !== 32'h0000_5000 || ddata_r !== model_rdata) begin
      failures++;
      $display("FAIL mid_rd_wait: read=%b addr=%h ddata_r=%h required 0 00005000 %h", avm_read, avm_address, ddata_r, model_rdata);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({avm_read, avm_write, done_ext, err} !== 4'b0000 ||
        ddata_r !== 32'h0 || avm_address !== 32'h0 || avm_writedata !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_async: ctrl=%b ddata_r=%h addr=%h wdata=%h required all 0",
               {avm_read, avm_write, done_ext, err}, ddata_r, avm_address, avm_writedata);
    end
    model_rdata = 32'h0;
    model_err   = 1'b0;
    RRam = 1'b0;
    @(posedge CLK); #1;
    RST_N             = 1'b1;
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h0BAD_F00D;
    @(posedge CLK); #1;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    checks++;
    if (ddata_r !== 32'h0 || done_ext !== 1'b0 || avm_read !== 1'b0) begin
      failures++;
      $display("FAIL late_rdv: ddata_r=%h done=%b read=%b required 0 0 0", ddata_r, done_ext, avm_read);
    end
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (done_ext !== 1'b0 || ddata_r !== 32'h0) begin
      failures++;
      $display("FAIL late_rdv_after: done=%b ddata_r=%h required 0 0", done_ext, ddata_r);
    end
  endtask

  task automatic test_reset_held_request();
    bit   d;
    int   n;
    exp_t e;
    slave_data  = 32'h2468_ACE0;
    model_rdata = slave_data;
    push_exp(model_rdata, model_err);
    RST_N = 1'b0;
    daddr = 32'h0000_600C;
    RRam  = 1'b1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    step_slave(d);
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'h0000_600C) begin
      failures++;
      $display("FAIL held_through_reset: read=%b addr=%h required 1 0000600c", avm_read, avm_address);
    end
    n = 0;
    while (!d && n < 20) begin
      step_slave(d);
      n++;
    end
    checks++;
    if (!d) begin
      failures++;
      $display("FAIL rst_req_done: no done_ext within %0d cycles", n);
    end else if (!pop_exp(e) || ddata_r !== e.rdata) begin
      failures++;
      $display("FAIL rst_req_data: ddata_r=%h required %h", ddata_r, model_rdata);
    end
    RRam = 1'b0;
    step_slave(d);
  endtask

`ifdef AVM_DATA_TIMEOUT_EN
  task automatic test_timeout();
    bit   d;
    int   n, rd_cycles;
    exp_t e;
    model_rdata = 32'hDEAD_BEEF;
    model_err   = 1'b1;
    push_exp(model_rdata, model_err);
    daddr           = 32'h0000_7000;
    avm_waitrequest = 1'b1;
    RRam            = 1'b1;
    n = 0;
    rd_cycles = 0;
    d = 1'b0;
    while (!d && n < 40) begin
      step_slave(d);
      if (avm_read === 1'b1) rd_cycles++;
      n++;
    end
    checks++;
    if (!d || rd_cycles != 8) begin
      failures++;
      $display("FAIL timeout_len: done=%0d read cycles=%0d required 1 8", d, rd_cycles);
    end
    checks++;
    if (!pop_exp(e)) begin
      failures++;
      $display("FAIL timeout_sb: done_ext with no expected entry");
    end else if (ddata_r !== e.rdata || err !== e.err) begin
      failures++;
      $display("FAIL timeout_data: ddata_r=%h err=%b required %h %b", ddata_r, err, e.rdata, e.err);
    end
    avm_waitrequest = 1'b0;
    RRam = 1'b0;
    repeat (3) step_slave(d);
    checks++;
    if (err !== 1'b1 || ddata_r !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL timeout_sticky: err=%b ddata_r=%h required 1 deadbeef", err, ddata_r);
    end
  endtask
`else
  task automatic test_no_timeout();
    bit   d;
    int   n, rd_cycles, dn;
    exp_t e;
    slave_data  = 32'h7777_0007;
    model_rdata = slave_data;
    push_exp(model_rdata, model_err);
    daddr           = 32'h0000_7000;
    avm_waitrequest = 1'b1;
    RRam            = 1'b1;
    rd_cycles = 0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      step_slave(d);
      if (avm_read === 1'b1) rd_cycles++;
      if (d || err !== 1'b0) dn++;
    end
    checks++;
    if (rd_cycles != 40 || dn != 0) begin
      failures++;
      $display("FAIL no_timeout_wait: read cycles=%0d done/err=%0d required 40 0", rd_cycles, dn);
    end
    avm_waitrequest = 1'b0;
    n = 0;
    d = 1'b0;
    while (!d && n < 20) begin
      step_slave(d);
      n++;
    end
    checks++;
    if (!d) begin
      failures++;
      $display("FAIL no_timeout_done: no done_ext within %0d cycles", n);
    end else if (!pop_exp(e) || ddata_r !== e.rdata || err !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout_data: ddata_r=%h err=%b required %h 0", ddata_r, err, model_rdata);
    end
    RRam = 1'b0;
    step_slave(d);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_simultaneous();
    test_held_level();
    test_reset_mid_read();
    test_reset_held_request();
`ifdef AVM_DATA_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d expected completions never seen, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
